// File: rtl/peri_timer_if.sv
// Peripheral bus bundle shared by data memory and memory-mapped blocks.
// The master drives address/data/strobe; the slave returns read data and its decode hit.
interface peri_timer_if;
  logic [10:0] addr;
  logic [15:0] wr_data;
  logic        write_enable;
  logic [15:0] rd_data;
  logic        hit;

  modport master (
    output addr,
    output wr_data,
    output write_enable,
    input  rd_data,
    input  hit
  );

  modport slave (
    input  addr,
    input  wr_data,
    input  write_enable,
    output rd_data,
    output hit
  );
endinterface

// File: rtl/peri_timer.sv
// Memory-mapped interval timer: prescaled tick counter, period match, W1C status
// and a registered, maskable interrupt request.
module peri_timer #(
  parameter logic [10:0] BASE_ADDR = 11'h7F0
) (
  input  logic         clk,
  input  logic         reset,
  peri_timer_if.slave  bus,
  output logic         irq
);

  logic        en_q, en_d;
  logic        reload_q, reload_d;
  logic        irq_en_q, irq_en_d;
  logic [3:0]  ps_q, ps_d;
  logic [15:0] count_q, count_d;
  logic [15:0] period_q, period_d;
  logic        pending_q, pending_d;
  logic        missed_q, missed_d;
  logic [15:0] pre_q, pre_d;
  logic        irq_q, irq_d;

  logic [11:0] offset_full;
  logic [1:0]  offset;
  logic        wr_ctrl, wr_count, wr_period, wr_status;
  logic [15:0] ps_mask;
  logic        tick;
  logic        match_tick;

  // Widened subtraction so addresses below BASE_ADDR land far outside the window.
  assign offset_full = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign offset      = offset_full[1:0];
  assign bus.hit     = (offset_full < 12'd4);

  assign wr_ctrl   = bus.write_enable & bus.hit & (offset == 2'd0);
  assign wr_count  = bus.write_enable & bus.hit & (offset == 2'd1);
  assign wr_period = bus.write_enable & bus.hit & (offset == 2'd2);
  assign wr_status = bus.write_enable & bus.hit & (offset == 2'd3);

  assign ps_mask    = (16'd1 << ps_q) - 16'd1;
  assign tick       = en_q & ((pre_q & ps_mask) == ps_mask);
  assign match_tick = tick & (count_q == period_q);

  always_comb begin
    en_d      = en_q;
    reload_d  = reload_q;
    irq_en_d  = irq_en_q;
    ps_d      = ps_q;
    count_d   = count_q;
    period_d  = period_q;
    pending_d = pending_q;
    missed_d  = missed_q;
    pre_d     = pre_q;

    if (en_q) begin
      pre_d = tick ? 16'd0 : pre_q + 16'd1;
    end

    if (match_tick && !reload_q) begin
      en_d = 1'b0;
    end
    if (wr_ctrl) begin
      en_d     = bus.wr_data[0];
      reload_d = bus.wr_data[1];
      irq_en_d = bus.wr_data[2];
      ps_d     = bus.wr_data[7:4];
      pre_d    = 16'd0;
    end

    if (tick) begin
      count_d = match_tick ? 16'd0 : count_q + 16'd1;
    end
    if (wr_count) begin
      count_d = bus.wr_data;
    end

    if (wr_period) begin
      period_d = bus.wr_data;
    end

    // W1C first so a same-cycle hardware set wins.
    if (wr_status) begin
      if (bus.wr_data[0]) pending_d = 1'b0;
      if (bus.wr_data[1]) missed_d  = 1'b0;
    end
    if (match_tick) begin
      pending_d = 1'b1;
      if (pending_q) missed_d = 1'b1;
    end

    irq_d = pending_d & irq_en_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= 1'b0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      ps_q      <= 4'd0;
      count_q   <= 16'd0;
      period_q  <= 16'hFFFF;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
      pre_q     <= 16'd0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      ps_q      <= ps_d;
      count_q   <= count_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
      pre_q     <= pre_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    bus.rd_data = 16'd0;
    if (bus.hit) begin
      unique case (offset)
        2'd0: bus.rd_data = {8'd0, ps_q, 1'b0, irq_en_q, reload_q, en_q};
        2'd1: bus.rd_data = count_q;
        2'd2: bus.rd_data = period_q;
        2'd3: bus.rd_data = {14'd0, missed_q, pending_q};
        default: bus.rd_data = 16'd0;
      endcase
    end
  end

endmodule
